// File: rtl/nps_inmem_sched.sv
// nps_inmem_sched: run controller for the NPS input-memory streaming block.
// Issues set/start pulses to inmem for a programmed number of frames, counts
// the valid beats of every frame against DATA_NUM and watches for stalls. While
// a run is in progress, CPU writes into the memory are blocked and reported.
// Build option: define NPS_SCHED_LOOP_EN to make cfg_frames=0 mean "run frames
// until abort or error". When it is not defined, cfg_frames=0 ends at once with
// an error-free done.
module nps_inmem_sched #(
    parameter int DATA_NUM    = 30,
    parameter int CNT_WIDTH   = 5,
    parameter int FRAME_WIDTH = 8,
    parameter int GAP_WIDTH   = 8,
    parameter int SET_WAIT    = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   reset_x,
    input  logic                   cmd_go,
    input  logic                   cmd_abort,
    input  logic [FRAME_WIDTH-1:0] cfg_frames,
    input  logic [GAP_WIDTH-1:0]   cfg_gap,
    output logic                   set,
    output logic                   start,
    input  logic                   vi,
    input  logic                   fi,
    input  logic                   cpu_wr_i,
    output logic                   cpu_wr_o,
    output logic                   cpu_wr_rej,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             err_code,
    output logic [FRAME_WIDTH-1:0] frame_idx,
    output logic [CNT_WIDTH-1:0]   beat_cnt
);

    // The wait counter serves both the set->start hold and the inter-frame gap.
    localparam int WAIT_BITS  = $clog2(SET_WAIT + 1);
    localparam int WAIT_WIDTH = (GAP_WIDTH > WAIT_BITS) ? GAP_WIDTH : WAIT_BITS;
    localparam int TO_WIDTH   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_WIDTH-1:0]  BEAT_MAX      = '1;
    localparam logic [CNT_WIDTH-1:0]  BEAT_TARGET   = CNT_WIDTH'(DATA_NUM);
    localparam logic [WAIT_WIDTH-1:0] SET_WAIT_LAST = WAIT_WIDTH'(SET_WAIT - 1);
    localparam logic [TO_WIDTH-1:0]   TIMEOUT_LAST  = TO_WIDTH'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_LENGTH  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        SETW,
        START,
        RUN,
        GAP,
        DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [WAIT_WIDTH-1:0]  wcnt, wcnt_nxt;
    logic [TO_WIDTH-1:0]    tcnt, tcnt_nxt;
    logic [FRAME_WIDTH-1:0] frames_q, frames_nxt;
    logic [GAP_WIDTH-1:0]   gap_q, gap_nxt;
    logic [1:0]             err_nxt;
    logic [FRAME_WIDTH-1:0] fidx_nxt;
    logic [CNT_WIDTH-1:0]   beat_nxt;

    logic [CNT_WIDTH-1:0]   beat_inc;
    logic [CNT_WIDTH-1:0]   beat_final;
    logic [FRAME_WIDTH-1:0] fidx_plus1;
    logic [WAIT_WIDTH-1:0]  gap_last;
    logic                   last_frame;
    logic                   zero_frames_done;

    assign beat_inc   = (beat_cnt == BEAT_MAX) ? beat_cnt : beat_cnt + CNT_WIDTH'(1);
    assign beat_final = vi ? beat_inc : beat_cnt;
    assign fidx_plus1 = frame_idx + FRAME_WIDTH'(1);
    assign gap_last   = WAIT_WIDTH'(gap_q) - WAIT_WIDTH'(1);

`ifdef NPS_SCHED_LOOP_EN
    // A zero frame count is continuous mode: no frame is ever the last one.
    assign last_frame       = (frames_q != '0) && (fidx_plus1 == frames_q);
    assign zero_frames_done = 1'b0;
`else
    assign last_frame       = (fidx_plus1 == frames_q);
    assign zero_frames_done = (cfg_frames == '0);
`endif

    // The write gate is the only combinational output, so the CPU sees no extra latency.
    assign cpu_wr_o = cpu_wr_i & ~busy;

    // Next-state and datapath decisions; abort overrides everything outside IDLE/DONE.
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        tcnt_nxt   = tcnt;
        frames_nxt = frames_q;
        gap_nxt    = gap_q;
        err_nxt    = err_code;
        fidx_nxt   = frame_idx;
        beat_nxt   = beat_cnt;

        case (state)
            IDLE: begin
                if (cmd_go && !cmd_abort) begin
                    frames_nxt = cfg_frames;
                    gap_nxt    = cfg_gap;
                    err_nxt    = ERR_OK;
                    fidx_nxt   = '0;
                    beat_nxt   = '0;
                    state_nxt  = zero_frames_done ? DONE : SET;
                end
            end
            SET: begin
                wcnt_nxt  = '0;
                state_nxt = (SET_WAIT == 0) ? START : SETW;
            end
            SETW: begin
                if (wcnt == SET_WAIT_LAST) begin
                    state_nxt = START;
                end else begin
                    wcnt_nxt = wcnt + WAIT_WIDTH'(1);
                end
            end
            START: begin
                beat_nxt  = '0;
                tcnt_nxt  = '0;
                state_nxt = RUN;
            end
            RUN: begin
                if (vi) begin
                    beat_nxt = beat_inc;
                    tcnt_nxt = '0;
                end else begin
                    tcnt_nxt = tcnt + TO_WIDTH'(1);
                end
                if (fi) begin
                    if (beat_final != BEAT_TARGET) begin
                        err_nxt   = ERR_LENGTH;
                        state_nxt = DONE;
                    end else if (last_frame) begin
                        state_nxt = DONE;
                    end else begin
                        fidx_nxt  = fidx_plus1;
                        wcnt_nxt  = '0;
                        state_nxt = GAP;
                    end
                end else if (!vi && (tcnt == TIMEOUT_LAST)) begin
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = DONE;
                end
            end
            GAP: begin
                if ((gap_q == '0) || (wcnt == gap_last)) begin
                    state_nxt = SET;
                end else begin
                    wcnt_nxt = wcnt + WAIT_WIDTH'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // DONE is already ending the run, so a late abort there leaves its result alone.
        if (cmd_abort && (state != IDLE) && (state != DONE)) begin
            state_nxt = DONE;
            err_nxt   = ERR_ABORT;
            fidx_nxt  = frame_idx;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, latched config and registered outputs (pulses decoded from the next state).
    always_ff @(posedge clk) begin
        if (!reset_x) begin
            wcnt       <= '0;
            tcnt       <= '0;
            frames_q   <= '0;
            gap_q      <= '0;
            err_code   <= ERR_OK;
            frame_idx  <= '0;
            beat_cnt   <= '0;
            set        <= 1'b0;
            start      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cpu_wr_rej <= 1'b0;
        end else begin
            wcnt       <= wcnt_nxt;
            tcnt       <= tcnt_nxt;
            frames_q   <= frames_nxt;
            gap_q      <= gap_nxt;
            err_code   <= err_nxt;
            frame_idx  <= fidx_nxt;
            beat_cnt   <= beat_nxt;
            set        <= (state_nxt == SET);
            start      <= (state_nxt == START);
            busy       <= (state_nxt != IDLE) && (state_nxt != DONE);
            done       <= (state_nxt == DONE);
            cpu_wr_rej <= cpu_wr_i & busy;
        end
    end

endmodule
